// File: rtl/checker_pkg.sv
// Shared definitions for the instruction checkpoint monitor.
//   - FSM state encoding
//   - first-failure cause codes reported on FAIL_CODE
//   - width of one stored table entry {num_inst, ans, mask}
package checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [1:0] FC_NONE     = 2'd0;
   localparam logic [1:0] FC_MISMATCH = 2'd1;
   localparam logic [1:0] FC_MISSED   = 2'd2;
   localparam logic [1:0] FC_TIMEOUT  = 2'd3;

   function automatic int entry_width(input int cwidth, input int dwidth);
      return cwidth + 2 * dwidth;
   endfunction

   localparam int ENTRY_W = entry_width(32, 32);

endpackage

// File: rtl/ckpt_table.sv
// Checkpoint table storage.
// Ports:
//   clk                          write clock
//   we, wr_idx, wr_num/ans/mask  single write port (registered)
//   rd_idx                       read index (current pointer)
//   rd_num, rd_ans, rd_mask      asynchronous read data
// Contents are deliberately not reset so a loaded table survives RST.
module ckpt_table
   import checker_pkg::*;
#(
   parameter int NUM_ENTRY = 64,
   parameter int IDX_W     = 6,
   parameter int CWIDTH    = 32,
   parameter int DWIDTH    = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [CWIDTH-1:0] wr_num,
   input  logic [DWIDTH-1:0] wr_ans,
   input  logic [DWIDTH-1:0] wr_mask,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic [CWIDTH-1:0] rd_num,
   output logic [DWIDTH-1:0] rd_ans,
   output logic [DWIDTH-1:0] rd_mask
);

   localparam int EW = entry_width(CWIDTH, DWIDTH);

   logic [EW-1:0] mem [NUM_ENTRY];

   always_ff @(posedge clk) begin
      if (we) mem[wr_idx] <= {wr_num, wr_ans, wr_mask};
   end

   assign {rd_num, rd_ans, rd_mask} = mem[rd_idx];

endmodule

// File: rtl/inst_checkpoint_monitor.sv
// Checkpoint scoreboard for the pipelined RISC-V core: walks a loadable
// table of (instruction count, expected value, mask) entries while the core
// runs and reports pass/fail status, first-failure detail and counters.
// Ports:
//   CLK, RST                    clock, asynchronous active-high reset
//   CFG_WE/IDX/NUM_INST/ANS/MASK table write (ignored while running)
//   CFG_COUNT, STOP_ON_FAIL     run configuration, latched on START
//   START                       run start pulse
//   NUM_INST, OUTPUT_PORT, HALT core observation
//   BUSY, DONE, ALL_PASS        run status
//   FAIL_VALID/IDX/CODE/DATA    first failure record
//   PASS_CNT, FAIL_CNT, CYCLE_CNT counters
//
// state   | meaning
// IDLE    | after reset, waiting for START
// RUN     | walking the table, one entry retired per cycle at most
// DONE    | run finished, results held until next START
module inst_checkpoint_monitor
   import checker_pkg::*;
#(
   parameter int          NUM_ENTRY  = 64,
   parameter int          IDX_W      = 6,
   parameter int          DWIDTH     = 32,
   parameter int          CWIDTH     = 32,
   parameter int unsigned MAX_CYCLES = 1000000
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CFG_WE,
   input  logic [IDX_W-1:0]  CFG_IDX,
   input  logic [CWIDTH-1:0] CFG_NUM_INST,
   input  logic [DWIDTH-1:0] CFG_ANS,
   input  logic [DWIDTH-1:0] CFG_MASK,
   input  logic [IDX_W:0]    CFG_COUNT,
   input  logic              STOP_ON_FAIL,
   input  logic              START,
   input  logic [CWIDTH-1:0] NUM_INST,
   input  logic [DWIDTH-1:0] OUTPUT_PORT,
   input  logic              HALT,
   output logic              BUSY,
   output logic              DONE,
   output logic              ALL_PASS,
   output logic              FAIL_VALID,
   output logic [IDX_W-1:0]  FAIL_IDX,
   output logic [1:0]        FAIL_CODE,
   output logic [DWIDTH-1:0] FAIL_DATA,
   output logic [IDX_W:0]    PASS_CNT,
   output logic [IDX_W:0]    FAIL_CNT,
   output logic [31:0]       CYCLE_CNT
);

   localparam logic [IDX_W-1:0] PTR_ONE = 1;
   localparam logic [IDX_W:0]   CNT_ONE = 1;

   state_t            state, state_nxt;
   logic [IDX_W-1:0]  ptr, ptr_nxt;
   logic [IDX_W:0]    count, count_nxt;
   logic              stop, stop_nxt;
   logic              all_pass_nxt, fail_valid_nxt;
   logic [IDX_W-1:0]  fail_idx_nxt;
   logic [1:0]        fail_code_nxt;
   logic [DWIDTH-1:0] fail_data_nxt;
   logic [IDX_W:0]    pass_cnt_nxt, fail_cnt_nxt;
   logic [31:0]       cycle_cnt_nxt;

   logic [CWIDTH-1:0] e_num;
   logic [DWIDTH-1:0] e_ans, e_mask;
   logic              hit, missed, retire, bad, last;

   ckpt_table #(
      .NUM_ENTRY (NUM_ENTRY),
      .IDX_W     (IDX_W),
      .CWIDTH    (CWIDTH),
      .DWIDTH    (DWIDTH)
   ) u_table (
      .clk     (CLK),
      .we      (CFG_WE && (state != ST_RUN)),
      .wr_idx  (CFG_IDX),
      .wr_num  (CFG_NUM_INST),
      .wr_ans  (CFG_ANS),
      .wr_mask (CFG_MASK),
      .rd_idx  (ptr),
      .rd_num  (e_num),
      .rd_ans  (e_ans),
      .rd_mask (e_mask)
   );

   assign BUSY = (state == ST_RUN);
   assign DONE = (state == ST_DONE);

   assign hit    = (NUM_INST == e_num);
   assign missed = (NUM_INST > e_num);
   assign retire = hit || missed;
   assign bad    = missed || (hit && (((OUTPUT_PORT ^ e_ans) & e_mask) != '0));
   assign last   = retire && ({1'b0, ptr} == (count - CNT_ONE));

   always_comb begin
      state_nxt      = state;
      ptr_nxt        = ptr;
      count_nxt      = count;
      stop_nxt       = stop;
      all_pass_nxt   = ALL_PASS;
      fail_valid_nxt = FAIL_VALID;
      fail_idx_nxt   = FAIL_IDX;
      fail_code_nxt  = FAIL_CODE;
      fail_data_nxt  = FAIL_DATA;
      pass_cnt_nxt   = PASS_CNT;
      fail_cnt_nxt   = FAIL_CNT;
      cycle_cnt_nxt  = CYCLE_CNT;

      case (state)
         ST_IDLE, ST_DONE: begin
            if (START) begin
               ptr_nxt        = '0;
               count_nxt      = CFG_COUNT;
               stop_nxt       = STOP_ON_FAIL;
               all_pass_nxt   = 1'b0;
               fail_valid_nxt = 1'b0;
               fail_idx_nxt   = '0;
               fail_code_nxt  = FC_NONE;
               fail_data_nxt  = '0;
               pass_cnt_nxt   = '0;
               fail_cnt_nxt   = '0;
               cycle_cnt_nxt  = '0;
               if (CFG_COUNT == '0) begin
                  state_nxt    = ST_DONE;
                  all_pass_nxt = 1'b1;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            cycle_cnt_nxt = (CYCLE_CNT == '1) ? CYCLE_CNT : CYCLE_CNT + 32'd1;
            if (retire) begin
               ptr_nxt = ptr + PTR_ONE;
               if (!bad) pass_cnt_nxt = PASS_CNT + CNT_ONE;
            end
            if (bad) begin
               fail_cnt_nxt = fail_cnt_nxt + CNT_ONE;
               if (!fail_valid_nxt) begin
                  fail_idx_nxt  = ptr;
                  fail_code_nxt = missed ? FC_MISSED : FC_MISMATCH;
                  fail_data_nxt = OUTPUT_PORT;
               end
               fail_valid_nxt = 1'b1;
            end
            if (last) begin
               state_nxt    = ST_DONE;
               all_pass_nxt = (fail_cnt_nxt == '0);
            end else if (HALT || (cycle_cnt_nxt >= MAX_CYCLES)) begin
               // The current entry was evaluated above; the halt/timeout is
               // charged to whichever entry is still pending afterwards.
               fail_cnt_nxt = fail_cnt_nxt + CNT_ONE;
               if (!fail_valid_nxt) begin
                  fail_idx_nxt  = ptr_nxt;
                  fail_code_nxt = FC_TIMEOUT;
                  fail_data_nxt = OUTPUT_PORT;
               end
               fail_valid_nxt = 1'b1;
               state_nxt      = ST_DONE;
               all_pass_nxt   = 1'b0;
            end else if (bad && stop) begin
               state_nxt    = ST_DONE;
               all_pass_nxt = 1'b0;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= ST_IDLE;
         ptr        <= '0;
         count      <= '0;
         stop       <= 1'b0;
         ALL_PASS   <= 1'b0;
         FAIL_VALID <= 1'b0;
         FAIL_IDX   <= '0;
         FAIL_CODE  <= FC_NONE;
         FAIL_DATA  <= '0;
         PASS_CNT   <= '0;
         FAIL_CNT   <= '0;
         CYCLE_CNT  <= '0;
      end else begin
         state      <= state_nxt;
         ptr        <= ptr_nxt;
         count      <= count_nxt;
         stop       <= stop_nxt;
         ALL_PASS   <= all_pass_nxt;
         FAIL_VALID <= fail_valid_nxt;
         FAIL_IDX   <= fail_idx_nxt;
         FAIL_CODE  <= fail_code_nxt;
         FAIL_DATA  <= fail_data_nxt;
         PASS_CNT   <= pass_cnt_nxt;
         FAIL_CNT   <= fail_cnt_nxt;
         CYCLE_CNT  <= cycle_cnt_nxt;
      end
   end

endmodule

// File: doc/inst_checkpoint_monitor.md
Name: inst_checkpoint_monitor

Overview:
- Synthesizable checkpoint scoreboard for the pipelined RISCV core.
- Holds a programmable table of (instruction-count, expected value, mask) entries and walks it in order while the core runs.
- Compares OUTPUT_PORT whenever NUM_INST reaches the current entry's checkpoint, and reports pass/fail, fail detail, counters and completion.
- Sits beside RISCV_TOP in bench and FPGA builds; replaces the fixed per-program test tables with a loadable one.

Parameters:
- NUM_ENTRY, 64, table depth (max checkpoints per program).
- IDX_W, 6, index width (at least clog2(NUM_ENTRY)).
- DWIDTH, 32, OUTPUT_PORT / expected-value width.
- CWIDTH, 32, NUM_INST width.
- MAX_CYCLES, 1000000, run timeout in cycles.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- CFG_WE  in  1  table write strobe (honoured only in IDLE/DONE)
- CFG_IDX  in  IDX_W  table write index
- CFG_NUM_INST  in  CWIDTH  checkpoint instruction count
- CFG_ANS  in  DWIDTH  expected value
- CFG_MASK  in  DWIDTH  compare mask (1 = bit checked)
- CFG_COUNT  in  IDX_W+1  active entries, sampled on START
- STOP_ON_FAIL  in  1  mode, sampled on START
- START  in  1  one-cycle run start pulse
- NUM_INST  in  CWIDTH  core retired-instruction count
- OUTPUT_PORT  in  DWIDTH  core observed value
- HALT  in  1  core halt
- BUSY  out  1  in RUN
- DONE  out  1  run finished (sticky until next START)
- ALL_PASS  out  1  valid with DONE: every active entry passed
- FAIL_VALID  out  1  sticky: at least one failure recorded
- FAIL_IDX  out  IDX_W  index of first failure
- FAIL_CODE  out  2  first-failure cause: 0 none, 1 mismatch, 2 missed, 3 timeout/early halt
- FAIL_DATA  out  DWIDTH  OUTPUT_PORT at first failure
- PASS_CNT  out  IDX_W+1  entries passed
- FAIL_CNT  out  IDX_W+1  entries failed or missed
- CYCLE_CNT  out  32  cycles spent in RUN

Behaviour:
- Reset: state IDLE, all outputs 0, pointer 0. Table contents are not reset.
- States: IDLE, RUN, DONE.
  - IDLE/DONE -> RUN on START. START clears counters, FAIL_* outputs, DONE, ALL_PASS and the pointer, and latches CFG_COUNT and STOP_ON_FAIL.
  - START with CFG_COUNT==0 goes straight to DONE with ALL_PASS=1.
  - START while in RUN is ignored.
- RUN, each posedge; E = table[ptr]:
  - Match: NUM_INST == E.num. If (OUTPUT_PORT & E.mask) == (E.ans & E.mask), PASS_CNT+1; otherwise a fail with code 1. Then ptr+1.
  - Missed: NUM_INST > E.num. Fail with code 2, ptr+1, no compare. Only one entry is retired per cycle, so several skipped entries drain over successive cycles.
  - Fail: FAIL_CNT+1. FAIL_IDX, FAIL_CODE and FAIL_DATA are written only if FAIL_VALID was 0 (first failure wins). FAIL_VALID is set.
  - If STOP_ON_FAIL, the cycle after a fail enters DONE.
  - When ptr retires entry CFG_COUNT-1, next state is DONE with ALL_PASS = (FAIL_CNT==0 including this entry).
  - HALT=1 with entries remaining: DONE, code 3 recorded as a fail at the current ptr. The comparison for the current entry in that same cycle is evaluated first.
  - CYCLE_CNT reaching MAX_CYCLES: same as early HALT.
- Registered outputs update one cycle after the matching input cycle. CYCLE_CNT saturates.
- NUM_INST is assumed monotonic. A decrease is not checked.
- CFG_WE during RUN is dropped. Table writes take effect the following cycle.
- RST mid-run: immediate IDLE, outputs cleared.

Decomposition:
- Shared package (checker_pkg): FAIL_CODE constants (FC_NONE, FC_MISMATCH, FC_MISSED, FC_TIMEOUT), state encodings, entry record width constant.
- One sub-module, ckpt_table: NUM_ENTRY x (CWIDTH+2*DWIDTH) register array with one write port and one asynchronous read port indexed by ptr.

Test Plan:
- Load 3 entries {4:0x0F00/FFFFFFFF, 6:0x18, 8:0x1D}, START, drive the matching sequence -> PASS_CNT=3, DONE=1, ALL_PASS=1, FAIL_VALID=0.
- Entry {10: ans 0x1E}, OUTPUT_PORT=0x1F at NUM_INST=10, STOP_ON_FAIL=1 -> FAIL_CODE=1, FAIL_IDX=0, FAIL_DATA=0x1F, DONE the next cycle.
- Mask 0x0000FFFF, ans 0x1234ABCD, OUTPUT_PORT 0xFFFFABCD -> pass. Entries {4,5}, NUM_INST jumps 3 -> 7, STOP_ON_FAIL=0 -> two code-2 fails on consecutive cycles, FAIL_IDX=0, FAIL_CNT=2.
- HALT asserted at NUM_INST=5 with entry {9} pending -> DONE, FAIL_CODE=3, ALL_PASS=0. With MAX_CYCLES=20 and no match -> timeout at CYCLE_CNT=20.
- RST pulse mid-run -> all outputs 0 asynchronously. CFG_WE during RUN leaves the table unchanged. A second START with CFG_COUNT=0 -> DONE with ALL_PASS=1.
